// File: rtl/pwm_capture_if.sv
// pwm_capture_if: register-side bundle for the PWM input-capture block.
//   cap_div      - tick prescaler, 0 disables capture
//   clear_status - one-cycle pulse, clears the sticky timeout flag
//   high_time    - last completed high time, in ticks
//   period       - last completed period (rise to rise), in ticks
//   cap_valid    - one-cycle pulse when high_time/period update
//   cap_count    - completed captures, wraps FF->00
//   timeout      - sticky, period counter saturated
//   level        - synchronized pwm_in
// master = register file side, slave = capture block side.
interface pwm_capture_if;
    logic [7:0]  cap_div;
    logic        clear_status;
    logic [15:0] high_time;
    logic [15:0] period;
    logic        cap_valid;
    logic [7:0]  cap_count;
    logic        timeout;
    logic        level;

    modport master (
        output cap_div, clear_status,
        input  high_time, period, cap_valid, cap_count, timeout, level
    );

    modport slave (
        input  cap_div, clear_status,
        output high_time, period, cap_valid, cap_count, timeout, level
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM pin and reports its high time and
// period (rise to rise) in prescaled ticks.
//   clock  - system clock
//   reset  - asynchronous, active-low reset
//   pwm_in - asynchronous external PWM input
//   bus    - register-side bundle (see pwm_capture_if)
// The prescaler ticks once every cap_div clocks and is re-phased on every
// synchronized rise, so each measurement starts on a tick boundary.
module pwm_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pwm_in,
    pwm_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [7:0]             pre_cnt_q, pre_cnt_d;
    logic [15:0]            per_cnt_q, per_cnt_d;
    logic [15:0]            hi_cnt_q, hi_cnt_d;
    logic [15:0]            high_time_q, high_time_d;
    logic [15:0]            period_q, period_d;
    logic [7:0]             cap_count_q, cap_count_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   timeout_q, timeout_d;

    logic       level, rise, fall, tick, enable;
    logic [8:0] pre_inc;

    assign level   = sync_q[SYNC_STAGES-1];
    assign rise    = level & ~hist_q;
    assign fall    = ~level & hist_q;
    assign enable  = |bus.cap_div;
    // A rise always counts as a tick so the new measurement starts aligned.
    assign tick    = (pre_cnt_q == 8'd0) | rise;
    assign pre_inc = {1'b0, pre_cnt_q} + 9'd1;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        cap_count_d = cap_count_q;
        cap_valid_d = 1'b0;
        timeout_d   = bus.clear_status ? 1'b0 : timeout_q;

        if (!enable) begin
            state_d   = ST_WAIT;
            pre_cnt_d = 8'd0;
            per_cnt_d = 16'd0;
            hi_cnt_d  = 16'd0;
        end else begin
            // Compare in 9 bits: a lowered cap_div below pre_cnt wraps to 0.
            if (rise)
                pre_cnt_d = (bus.cap_div <= 8'd1) ? 8'd0 : 8'd1;
            else if (pre_inc >= {1'b0, bus.cap_div})
                pre_cnt_d = 8'd0;
            else
                pre_cnt_d = pre_inc[7:0];

            if (rise) begin
                if (state_q == ST_LOW) begin
                    high_time_d = hi_cnt_q;
                    period_d    = per_cnt_q;
                    cap_valid_d = 1'b1;
                    cap_count_d = cap_count_q + 8'd1;
                end
                state_d   = ST_HIGH;
                per_cnt_d = 16'd1;
                hi_cnt_d  = 16'd1;
            end else if (state_q == ST_HIGH || state_q == ST_LOW) begin
                if (tick && per_cnt_q == 16'hFFFF) begin
                    // Saturation beats a simultaneous fall and clear_status.
                    state_d   = ST_WAIT;
                    per_cnt_d = 16'd0;
                    hi_cnt_d  = 16'd0;
                    timeout_d = 1'b1;
                end else begin
                    if (tick) begin
                        per_cnt_d = per_cnt_q + 16'd1;
                        if (state_q == ST_HIGH && !fall)
                            hi_cnt_d = hi_cnt_q + 16'd1;
                    end
                    if (state_q == ST_HIGH && fall)
                        state_d = ST_LOW;
                end
            end else begin
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_WAIT;
            sync_q      <= '0;
            hist_q      <= 1'b0;
            pre_cnt_q   <= 8'd0;
            per_cnt_q   <= 16'd0;
            hi_cnt_q    <= 16'd0;
            high_time_q <= 16'd0;
            period_q    <= 16'd0;
            cap_count_q <= 8'd0;
            cap_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            pre_cnt_q   <= pre_cnt_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            cap_count_q <= cap_count_d;
            cap_valid_q <= cap_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.high_time = high_time_q;
    assign bus.period    = period_q;
    assign bus.cap_valid = cap_valid_q;
    assign bus.cap_count = cap_count_q;
    assign bus.timeout   = timeout_q;
    assign bus.level     = level;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives pwm_capture with directed and random waveforms and
// compares every output, every cycle, against a behavioural model, plus
// literal expectations after each directed scenario.
module tb_pwm_capture;
    localparam int S = 2;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic pwm_in = 1'b0;

    pwm_capture_if bus();

    pwm_capture #(.SYNC_STAGES(S)) dut (
        .clock  (clock),
        .reset  (reset),
        .pwm_in (pwm_in),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit abort  = 1'b0;

    // Model: pin samples as a delay line, measurement as plain integers.
    bit m_sh [0:S];
    int m_mode;          // 0 idle/waiting, 1 measuring high, 2 measuring low
    int m_pre, m_per, m_hi, m_ht, m_pd, m_cnt;
    bit m_valid, m_to, m_level;

    function automatic void model_reset();
        for (int i = 0; i <= S; i++) m_sh[i] = 1'b0;
        m_mode = 0; m_pre = 0; m_per = 0; m_hi = 0;
        m_ht = 0; m_pd = 0; m_cnt = 0;
        m_valid = 1'b0; m_to = 1'b0; m_level = 1'b0;
    endfunction

    function automatic void model_edge(input bit p, input int d, input bit c);
        bit lv, hv, rise, fall, tick, sat;
        lv   = m_sh[S-1];
        hv   = m_sh[S];
        rise = lv && !hv;
        fall = !lv && hv;
        for (int i = S; i > 0; i--) m_sh[i] = m_sh[i-1];
        m_sh[0] = p;
        m_level = m_sh[S-1];
        m_valid = 1'b0;
        sat     = 1'b0;
        if (d == 0) begin
            m_mode = 0; m_pre = 0; m_per = 0; m_hi = 0;
        end else begin
            tick = (m_pre == 0) || rise;
            if (rise) m_pre = (d <= 1) ? 0 : 1;
            else      m_pre = (m_pre + 1 >= d) ? 0 : m_pre + 1;
            if (rise) begin
                if (m_mode == 2) begin
                    m_ht = m_hi; m_pd = m_per; m_valid = 1'b1;
                    m_cnt = (m_cnt + 1) % 256;
                end
                m_mode = 1; m_per = 1; m_hi = 1;
            end else if (m_mode != 0 && tick) begin
                if (m_per == 65535) begin
                    sat = 1'b1; m_mode = 0; m_per = 0; m_hi = 0;
                end else begin
                    m_per++;
                    if (m_mode == 1 && !fall) m_hi++;
                end
            end
            if (!rise && !sat && fall && m_mode == 1) m_mode = 2;
        end
        if (sat)    m_to = 1'b1;
        else if (c) m_to = 1'b0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("level",     bus.level,     m_level);
        chk("cap_valid", bus.cap_valid, m_valid);
        chk("high_time", bus.high_time, m_ht);
        chk("period",    bus.period,    m_pd);
        chk("cap_count", bus.cap_count, m_cnt);
        chk("timeout",   bus.timeout,   m_to);
    endtask

    // Called at a negedge: apply inputs, advance model over the next posedge,
    // then compare at the following negedge.
    task automatic cycle(input bit p, input int d, input bit c);
        if (abort) return;
        pwm_in           = p;
        bus.cap_div      = d[7:0];
        bus.clear_status = c;
        if (!reset) model_reset();
        else        model_edge(p, d, c);
        @(negedge clock);
        check_all();
        if (errors >= 40) abort = 1'b1;
    endtask

    task automatic wave(input int hi, input int lo, input int n, input int d);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < hi; i++) cycle(1'b1, d, 1'b0);
            for (int i = 0; i < lo; i++) cycle(1'b0, d, 1'b0);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_high_time"}, bus.high_time, 0);
        chk({tag, "_period"},    bus.period,    0);
        chk({tag, "_cap_valid"}, bus.cap_valid, 0);
        chk({tag, "_cap_count"}, bus.cap_count, 0);
        chk({tag, "_timeout"},   bus.timeout,   0);
        chk({tag, "_level"},     bus.level,     0);
    endtask

    initial begin
        int d;
        bus.cap_div      = 8'd0;
        bus.clear_status = 1'b0;
        #1 reset = 1'b0;
        #2 chk_zero_outputs("reset");
        model_reset();
        @(negedge clock);
        cycle(1'b0, 1, 1'b0);
        cycle(1'b0, 1, 1'b0);
        reset = 1'b1;

        // 1: div=1, 3 high / 5 low; first rise is from idle.
        wave(0, 5, 1, 1);
        wave(3, 5, 4, 1);
        chk("p1_high_time", bus.high_time, 3);
        chk("p1_period",    bus.period,    8);
        chk("p1_cap_count", bus.cap_count, 3);

        // 2: div=2, 4/4, then disabled, then re-enabled.
        wave(4, 4, 4, 2);
        chk("p2_high_time", bus.high_time, 2);
        chk("p2_period",    bus.period,    4);
        chk("p2_cap_count", bus.cap_count, 7);
        wave(4, 4, 2, 0);
        chk("p2_off_high_time", bus.high_time, 2);
        chk("p2_off_period",    bus.period,    4);
        chk("p2_off_cap_count", bus.cap_count, 7);
        wave(4, 4, 3, 2);
        chk("p2_on_cap_count", bus.cap_count, 9);
        chk("p2_on_period",    bus.period,    4);

        // 3+4: stuck high until saturation, clear_status on the same cycle.
        cycle(1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);
        for (int i = 0; i < 66000; i++)
            cycle(1'b1, 1, (m_mode == 1 && m_per == 65535));
        chk("p3_timeout",   bus.timeout,   1);
        chk("p3_high_time", bus.high_time, 2);
        chk("p3_period",    bus.period,    4);
        chk("p3_cap_count", bus.cap_count, 9);
        cycle(1'b1, 1, 1'b1);
        chk("p3_cleared", bus.timeout, 0);
        wave(0, 5, 1, 1);
        wave(3, 5, 3, 1);
        chk("p3_resume_high_time", bus.high_time, 3);
        chk("p3_resume_period",    bus.period,    8);
        chk("p3_resume_cap_count", bus.cap_count, 11);

        // 5: asynchronous reset while measuring high.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1, 1'b0);
        if (!abort) begin
            #2 reset = 1'b0;
            #1 chk_zero_outputs("async_reset");
            model_reset();
            pwm_in = 1'b0;
            @(negedge clock);
        end else begin
            reset = 1'b0;
            model_reset();
        end
        cycle(1'b0, 1, 1'b0);
        cycle(1'b0, 1, 1'b0);
        reset = 1'b1;
        wave(0, 4, 1, 1);
        wave(3, 5, 3, 1);
        chk("p5_high_time", bus.high_time, 3);
        chk("p5_period",    bus.period,    8);
        chk("p5_cap_count", bus.cap_count, 2);

        // 6: 257 rises of a 1/1 waveform -> 256 captures, count wraps.
        cycle(1'b0, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);
        wave(1, 1, 257, 1);
        wave(0, 4, 1, 1);
        chk("p6_high_time", bus.high_time, 1);
        chk("p6_period",    bus.period,    2);
        chk("p6_cap_count", bus.cap_count, 2);

        // 7: random waveforms, random divider changes, random clears.
        d = 1;
        for (int k = 0; k < 300; k++) begin
            int h, l;
            h = $urandom_range(1, 10);
            l = $urandom_range(1, 10);
            if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 5);
            for (int i = 0; i < h; i++) begin
                if ($urandom_range(0, 31) == 0) d = $urandom_range(0, 5);
                cycle(1'b1, d, ($urandom_range(0, 15) == 0));
            end
            for (int i = 0; i < l; i++) begin
                if ($urandom_range(0, 31) == 0) d = $urandom_range(0, 5);
                cycle(1'b0, d, ($urandom_range(0, 15) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
